lookup_ram_rd_pipe: RTL
=======================

// Module: lookup_ram_rd_pipe
// PURPOSE
//  Parametrised simple-dual-port lookup RAM with a flow-controlled read path for parser/action tables.
//  Control plane writes entries on port A. Datapath issues tagged read requests on port B (valid/ready).
//  Responses return in order with the request tag, through a small fall-through response FIFO.
//  The FIFO absorbs downstream backpressure, so no response is ever dropped.
// PARAMETERS
//  DATA_W       160  entry width in bits
//  ADDR_W       5    address width; depth = 2**ADDR_W
//  TAG_W        8    request tag width, returned unchanged with the data
//  RD_LAT       1    RAM read latency in cycles, legal 1 or 2 (2 = registered output)
//  RSP_DEPTH_W  2    response FIFO depth = 2**RSP_DEPTH_W; must satisfy 2**RSP_DEPTH_W >= RD_LAT+1
// PORTS
//  clk           in   1        clock
//  rst_n         in   1        synchronous, active-low reset
//  wr_en         in   1        write strobe, always accepted
//  wr_addr       in   ADDR_W   write address
//  wr_data       in   DATA_W   write data
//  rd_req_valid  in   1        read request valid
//  rd_req_ready  out  1        read request accepted when valid&&ready
//  rd_req_addr   in   ADDR_W   read address
//  rd_req_tag    in   TAG_W    opaque request tag
//  rd_rsp_valid  out  1        response valid (FIFO non-empty)
//  rd_rsp_ready  in   1        response pop when valid&&ready
//  rd_rsp_data   out  DATA_W   entry read
//  rd_rsp_tag    out  TAG_W    tag of the matching request
//  credits_used  out  RSP_DEPTH_W+1  in-flight reads plus stored responses
// BEHAVIOUR
//  Reset: rd_req_ready=0, rd_rsp_valid=0, credits_used=0. Pipeline valids and FIFO pointers are cleared.
//  RAM contents are not cleared.
//  rd_req_ready = rst_n_q && (credits_used < 2**RSP_DEPTH_W); it is combinational from registered state only.
//  rd_req_ready returns to 1 on the first cycle after reset deasserts.
//  Accept a request: the tag and a valid bit enter an RD_LAT-deep shift register aligned with the RAM read.
//  Data and tag are pushed into the FIFO in the cycle RD_LAT clocks after accept.
//  Earliest rd_rsp_valid is RD_LAT+1 cycles after accept.
//  Accepts and pops may both occur every cycle, giving full throughput of 1 response/cycle with ready held high.
//  credits_used: +1 on accept, -1 on pop, unchanged when both occur in the same cycle.
//  Never exceeds 2**RSP_DEPTH_W, so the FIFO cannot overflow.
//  FIFO is fall-through: rd_rsp_data/tag show the head entry whenever rd_rsp_valid=1.
//  Data/tag are held stable while valid && !ready.
//  Order: responses are strictly in request-accept order.
//  Collision (wr_en && rd accept && wr_addr==rd_req_addr in the same cycle): read-first, old data returned.
//  A write in any later cycle is not visible to reads already accepted.
//  Reset mid-operation: in-flight reads and stored responses are discarded; no response after reset.
// CONFIGURATION
//  LOOKUP_RAM_WR_BYPASS_EN defined: on a same-cycle collision, the response carries wr_data (write-first).
//   A bypass-select bit and a wr_data copy are pipelined alongside the tag.
//  Undefined: read-first as above; no bypass logic is instantiated.
// STRUCTURE
//  lookup_ram_pkg: RD_LAT_MAX=2, the credit width function clog2(depth)+1, and the rsp_t struct {tag, data}.
//  Sub-module lookup_ram_sdp: the inferred SDP RAM array, with the RD_LAT output register stage selectable.
//  The top level holds the tag/valid pipeline, the credit counter and the response FIFO.
// TESTING
//  1 Write 0x1111..11@1, 0x2222..22@2, 0x3333..33@3. Read 1,2,3,1,2,3 back-to-back with tags 0..5 and rsp_ready=1.
//    -> 6 in-order responses, tags 0..5, data matching, one per cycle, first at accept+RD_LAT+1.
//  2 Hold rsp_ready=0 and issue reads. -> exactly 2**RSP_DEPTH_W accepted, then rd_req_ready=0, credits_used=4.
//    Release ready -> 4 responses drain; rd_req_ready returns 1 the cycle after the first pop.
//  3 Same cycle: write 0xAAAA..AA@5 and read @5 (old 0x55..55).
//    -> 0x55..55 without the macro, 0xAA..AA with LOOKUP_RAM_WR_BYPASS_EN. A read @5 next cycle -> 0xAA..AA.
//  4 Toggle rsp_ready every cycle under continuous requests. -> no lost or duplicated tags.
//    credits_used stays <= 4; data stable while stalled.
//  5 Assert rst_n=0 with 3 reads in flight. -> rd_rsp_valid=0 and credits_used=0 the next cycle.
//    No stale response afterwards; RAM entries are still readable.
//  6 Repeat scenarios 1-4 with RD_LAT=2 -> same results, latency +1.

Source files
------------

// File: rtl/lookup_ram_pkg.sv
// Shared types and constants for the lookup RAM read pipeline.
package lookup_ram_pkg;

    localparam int RD_LAT_MAX = 2;
    localparam int DATA_W_DEF = 160;
    localparam int TAG_W_DEF  = 8;

    // Counter must hold the value 'depth' itself, hence the extra bit.
    function automatic int credit_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic [TAG_W_DEF-1:0]  tag;
        logic [DATA_W_DEF-1:0] data;
    } rsp_t;

endpackage

// File: rtl/lookup_ram_sdp.sv
// Inferred simple-dual-port RAM, read-first on address collision.
// Read data appears RD_LAT cycles after rd_en; no backpressure (always accepts).
// Write port always accepted; read port is enable-qualified.
module lookup_ram_sdp
    import lookup_ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = 5,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_q <= mem[rd_addr];
    end

    generate
        if (RD_LAT == RD_LAT_MAX) begin : g_oreg
            logic [DATA_W-1:0] rd_q2;
            always_ff @(posedge clk) rd_q2 <= rd_q;
            assign rd_data = rd_q2;
        end else begin : g_noreg
            assign rd_data = rd_q;
        end
    endgenerate

endmodule

// File: rtl/lookup_ram_rd_pipe.sv
// Lookup RAM with tagged, in-order, credit-limited read path (LOOKUP_RAM_WR_BYPASS_EN: write-first collisions).
// Latency: response valid RD_LAT+1 cycles after accept; 1 response/cycle sustained.
// Backpressure: responses wait in a fall-through FIFO; requests stall when credits are exhausted.
module lookup_ram_rd_pipe
    import lookup_ram_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = 5,
    parameter int TAG_W       = TAG_W_DEF,
    parameter int RD_LAT      = 1,
    parameter int RSP_DEPTH_W = 2
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      wr_en,
    input  logic [ADDR_W-1:0]                         wr_addr,
    input  logic [DATA_W-1:0]                         wr_data,
    input  logic                                      rd_req_valid,
    output logic                                      rd_req_ready,
    input  logic [ADDR_W-1:0]                         rd_req_addr,
    input  logic [TAG_W-1:0]                          rd_req_tag,
    output logic                                      rd_rsp_valid,
    input  logic                                      rd_rsp_ready,
    output logic [DATA_W-1:0]                         rd_rsp_data,
    output logic [TAG_W-1:0]                          rd_rsp_tag,
    output logic [credit_w(2**RSP_DEPTH_W)-1:0]       credits_used
);

    localparam int DEPTH = 2**RSP_DEPTH_W;
    localparam int CW    = credit_w(DEPTH);

    logic                   rst_n_q;
    logic                   accept;
    logic                   pop;
    logic                   push;
    logic [RD_LAT-1:0]      pipe_vld;
    logic [TAG_W-1:0]       pipe_tag [RD_LAT];
    logic [DATA_W-1:0]      ram_rd_data;
    logic [DATA_W-1:0]      push_data;
    logic [RSP_DEPTH_W:0]   wptr;
    logic [RSP_DEPTH_W:0]   rptr;
    rsp_t                   fifo_mem [DEPTH];

    // Ready depends only on registered state, so it holds low for the first reset-release cycle.
    assign rd_req_ready = rst_n_q && (credits_used < CW'(DEPTH));
    assign accept       = rd_req_valid && rd_req_ready;
    assign rd_rsp_valid = (wptr != rptr);
    assign pop          = rd_rsp_valid && rd_rsp_ready;
    assign push         = pipe_vld[RD_LAT-1];

    lookup_ram_sdp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (accept),
        .rd_addr (rd_req_addr),
        .rd_data (ram_rd_data)
    );

    always_ff @(posedge clk) rst_n_q <= rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_vld     <= '0;
            credits_used <= '0;
            wptr         <= '0;
            rptr         <= '0;
        end else begin
            pipe_vld[0] <= accept;
            for (int i = 1; i < RD_LAT; i++) pipe_vld[i] <= pipe_vld[i-1];
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({accept, pop})
                2'b10:   credits_used <= credits_used + CW'(1);
                2'b01:   credits_used <= credits_used - CW'(1);
                default: credits_used <= credits_used;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        pipe_tag[0] <= rd_req_tag;
        for (int i = 1; i < RD_LAT; i++) pipe_tag[i] <= pipe_tag[i-1];
    end

`ifdef LOOKUP_RAM_WR_BYPASS_EN
    logic [RD_LAT-1:0] pipe_byp;
    logic [DATA_W-1:0] pipe_wdat [RD_LAT];

    always_ff @(posedge clk) begin
        pipe_byp[0]  <= accept && wr_en && (wr_addr == rd_req_addr);
        pipe_wdat[0] <= wr_data;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_byp[i]  <= pipe_byp[i-1];
            pipe_wdat[i] <= pipe_wdat[i-1];
        end
    end

    assign push_data = pipe_byp[RD_LAT-1] ? pipe_wdat[RD_LAT-1] : ram_rd_data;
`else
    assign push_data = ram_rd_data;
`endif

    // Credits bound occupancy to DEPTH, so push never needs a full check.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wptr[RSP_DEPTH_W-1:0]] <= '{tag: pipe_tag[RD_LAT-1], data: push_data};
    end

    assign rd_rsp_data = fifo_mem[rptr[RSP_DEPTH_W-1:0]].data;
    assign rd_rsp_tag  = fifo_mem[rptr[RSP_DEPTH_W-1:0]].tag;

endmodule
